// File: rtl/uart_tx_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl_pkg
// Shared definitions for the UART transmit controller and its baud generator:
// default parameters, the TX sequencer state encoding, the register-bank
// address map and the Control/Status bit positions.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_tx_ctrl_pkg;

    localparam int UBRR_W_DEF     = 12;
    localparam int OVERSAMPLE_DEF = 16;
    localparam int FRAME_BITS_DEF = 10;
    localparam int TO_MARGIN_DEF  = 2;

    // state | meaning
    // IDLE  | waiting for a byte in the holding buffer with TxEn set
    // LOAD  | shifter captures the buffer, buffer reported empty again
    // ALIGN | waiting for a bit boundary to issue TxStart
    // BUSY  | frame on the line, counting bit periods for the timeout
    // DONE  | frame finished: chain next byte or raise TXC
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ALIGN,
        ST_BUSY,
        ST_DONE
    } tx_state_e;

    localparam logic [7:0] ADDR_TX_BUF = 8'h00;
    localparam logic [7:0] ADDR_RX_BUF = 8'h01;
    localparam logic [7:0] ADDR_CTRL0  = 8'h02;
    localparam logic [7:0] ADDR_STATUS = 8'h03;
    localparam logic [7:0] ADDR_UBRR_L = 8'h04;
    localparam logic [7:0] ADDR_UBRR_H = 8'h05;

    localparam int CTRL0_TXEN  = 0;
    localparam int CTRL0_RXEN  = 1;
    localparam int CTRL0_TXCIE = 2;
    localparam int CTRL0_UDRIE = 3;

    localparam int STAT_UDRE  = 0;
    localparam int STAT_TXC   = 1;
    localparam int STAT_TXOVR = 2;
    localparam int STAT_TXTO  = 3;

    // Width of a counter that must be able to hold the value 'limit'.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl_if
// Groups the register-bank / shifter handshake of the TX controller.
//   master : register bank + shifter side (drives config, strobes, TxDone)
//   slave  : uart_tx_ctrl (drives ticks, load/start strobes, flags, IRQ)
// -----------------------------------------------------------------------------
interface uart_tx_ctrl_if #(
    parameter int UBRR_W = 12
);
    logic              TxEn;
    logic              TxCIE;
    logic              UDRIE;
    logic [UBRR_W-1:0] Ubrr;
    logic              TxBWrite;
    logic              TxcClr;
    logic              ErrClr;
    logic              TxDone;

    logic              Tick16;
    logic              BitTick;
    logic              TxLoad;
    logic              TxStart;
    logic              UDRE;
    logic              TXC;
    logic              TxOvr;
    logic              TxTo;
    logic              TxIRQ;

    modport master (
        output TxEn, TxCIE, UDRIE, Ubrr, TxBWrite, TxcClr, ErrClr, TxDone,
        input  Tick16, BitTick, TxLoad, TxStart, UDRE, TXC, TxOvr, TxTo, TxIRQ
    );

    modport slave (
        input  TxEn, TxCIE, UDRIE, Ubrr, TxBWrite, TxcClr, ErrClr, TxDone,
        output Tick16, BitTick, TxLoad, TxStart, UDRE, TXC, TxOvr, TxTo, TxIRQ
    );
endinterface

// File: rtl/uart_tx_ctrl_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl_baud_gen
// Baud tick generator shared by TX and RX. A down-counter reloads from Ubrr
// each time it reaches zero (tick16 period = Ubrr+1 clocks); a sub-counter
// divides tick16 by OVERSAMPLE to produce the bit-period tick.
//   pClk, pReset   clock, async active-low reset
//   en_i           enable; when low the counter is parked at Ubrr, no ticks
//   ubrr_i         baud divisor, sampled only at reload
//   tick16_o       oversample tick
//   bit_tick_o     bit-period tick (coincides with a tick16)
// -----------------------------------------------------------------------------
module uart_tx_ctrl_baud_gen
    import uart_tx_ctrl_pkg::*;
#(
    parameter int UBRR_W     = UBRR_W_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              en_i,
    input  logic [UBRR_W-1:0] ubrr_i,
    output logic              tick16_o,
    output logic              bit_tick_o
);
    localparam int SUB_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    logic [UBRR_W-1:0] cnt_q, cnt_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic              tick;

    // Reset gating keeps the tick low while pReset is asserted even though
    // the counter resets to zero.
    assign tick       = en_i & pReset & (cnt_q == '0);
    assign tick16_o   = tick;
    assign bit_tick_o = tick & (sub_q == SUB_W'(OVERSAMPLE - 1));

    always_comb begin
        cnt_d = cnt_q;
        sub_d = sub_q;
        if (!en_i) begin
            cnt_d = ubrr_i;
            sub_d = '0;
        end else if (tick) begin
            cnt_d = ubrr_i;
            sub_d = sub_q + 1'b1;   // OVERSAMPLE is a power of two: natural wrap
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            cnt_q <= '0;
            sub_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sub_q <= sub_d;
        end
    end
endmodule

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// Transmit-side sequencer between the UART register bank and the TX shifter.
// Owns the holding-buffer flag (UDRE), TX-complete (TXC), overrun (TxOvr) and
// TxDone-timeout (TxTo) flags, and sequences TxLoad / bit-aligned TxStart.
//   pClk, pReset   clock, async active-low reset
//   bus (slave)    config, strobes and TxDone in; ticks, strobes, flags, IRQ out
// -----------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int UBRR_W     = UBRR_W_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int TO_MARGIN  = TO_MARGIN_DEF
) (
    input  logic          pClk,
    input  logic          pReset,
    uart_tx_ctrl_if.slave bus
);
    localparam int TO_LIMIT = FRAME_BITS + TO_MARGIN;
    localparam int BCNT_W   = cnt_width(TO_LIMIT);

    tx_state_e         state_q;
    logic              load_q;
    logic              udre_q;
    logic              txc_q;
    logic              ovr_q;
    logic              to_q;
    logic [BCNT_W-1:0] bcnt_q;

    logic              tick16;
    logic              bit_tick;
    logic              tx_start;

    uart_tx_ctrl_baud_gen #(
        .UBRR_W     (UBRR_W),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud (
        .pClk       (pClk),
        .pReset     (pReset),
        .en_i       (bus.TxEn),
        .ubrr_i     (bus.Ubrr),
        .tick16_o   (tick16),
        .bit_tick_o (bit_tick)
    );

    // TxStart has to land on the very cycle of the bit tick, so it is decoded
    // from the registered state rather than registered itself.
    assign tx_start = (state_q == ST_ALIGN) & bit_tick;

    // Later assignments in this block take priority: clears are written
    // first so a same-cycle set of the flag wins.
    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            state_q <= ST_IDLE;
            load_q  <= 1'b0;
            udre_q  <= 1'b1;
            txc_q   <= 1'b0;
            ovr_q   <= 1'b0;
            to_q    <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            load_q <= 1'b0;

            if (bus.ErrClr) begin
                ovr_q <= 1'b0;
                to_q  <= 1'b0;
            end
            if (bus.TxcClr) begin
                txc_q <= 1'b0;
            end
            // Buffer occupancy is judged on the registered flag, so a write
            // during LOAD still counts as an overrun.
            if (bus.TxBWrite) begin
                if (udre_q) begin
                    udre_q <= 1'b0;
                end else begin
                    ovr_q <= 1'b1;
                end
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (!udre_q && bus.TxEn) begin
                        state_q <= ST_LOAD;
                        load_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    udre_q  <= 1'b1;
                    txc_q   <= 1'b0;
                    state_q <= ST_ALIGN;
                end
                ST_ALIGN: begin
                    if (!bus.TxEn) begin
                        state_q <= ST_IDLE;
                    end else if (bit_tick) begin
                        bcnt_q  <= '0;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.TxDone) begin
                        state_q <= ST_DONE;
                    end else if (bit_tick) begin
                        bcnt_q <= bcnt_q + 1'b1;
                        if (bcnt_q == BCNT_W'(TO_LIMIT - 1)) begin
                            to_q    <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!udre_q && bus.TxEn) begin
                        state_q <= ST_LOAD;
                        load_q  <= 1'b1;
                    end else begin
                        txc_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Tick16  = tick16;
    assign bus.BitTick = bit_tick;
    assign bus.TxLoad  = load_q;
    assign bus.TxStart = tx_start;
    assign bus.UDRE    = udre_q;
    assign bus.TXC     = txc_q;
    assign bus.TxOvr   = ovr_q;
    assign bus.TxTo    = to_q;
    assign bus.TxIRQ   = pReset & ((bus.TxCIE & txc_q)
                                 | (bus.UDRIE & udre_q & bus.TxEn)
                                 | ovr_q | to_q);
endmodule
